// File: rtl/shift_sequencer.sv
// Command sequencer for the 8-bit universal shift register: accepts one command
// over valid/ready and replays it as N registered one-hot strobe cycles with serial-in.
module shift_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [7:0]       cmd_si,
    input  logic             abort,
    output logic             pl,
    output logic             sl,
    output logic             sr,
    output logic             rr,
    output logic             rl,
    output logic             si,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;

    function automatic logic op_legal(input logic [2:0] op);
        return (op >= OP_LOAD) && (op <= OP_ROL);
    endfunction

    // Strobe vector is ordered {pl, sl, sr, rr, rl}.
    function automatic logic [4:0] strobe_of(input logic [2:0] op);
        logic [4:0] s;
        s = 5'b00000;
        case (op)
            OP_LOAD: s = 5'b10000;
            OP_SHL:  s = 5'b01000;
            OP_SHR:  s = 5'b00100;
            OP_ROR:  s = 5'b00010;
            OP_ROL:  s = 5'b00001;
            default: s = 5'b00000;
        endcase
        return s;
    endfunction

    function automatic logic uses_si(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pat_q, pat_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       strb_q, strb_d;
    logic             si_q, si_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        strb_d  = 5'b00000;
        si_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!op_legal(cmd_op)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if ((cmd_op != OP_LOAD) && (cmd_cnt == '0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // First step's strobe and serial bit are registered on the accept edge.
                        state_d = S_RUN;
                        op_d    = cmd_op;
                        pat_d   = cmd_si;
                        cnt_d   = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_cnt;
                        strb_d  = strobe_of(cmd_op);
                        si_d    = uses_si(cmd_op) & cmd_si[0];
                        idx_d   = 3'd1;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort || (cnt_q == CNT_W'(1))) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    // idx_q wraps at 8, giving the mod-8 pattern index for free.
                    cnt_d  = cnt_q - CNT_W'(1);
                    strb_d = strobe_of(op_q);
                    si_d   = uses_si(op_q) & pat_q[idx_q];
                    idx_d  = idx_q + 3'd1;
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            cnt_q   <= '0;
            pat_q   <= 8'd0;
            idx_q   <= 3'd0;
            strb_q  <= 5'b00000;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            si_q    <= si_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign {pl, sl, sr, rr, rl} = strb_q;
    assign si   = si_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    // Registered outputs must always agree with the state they describe.
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(strb_q));
    a_busy_run: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state_q == S_RUN));
    a_strb_run: assert property (@(posedge clk) disable iff (!rst_n)
        (strb_q != 5'b00000) == (state_q == S_RUN));
    a_done_state: assert property (@(posedge clk) disable iff (!rst_n)
        done_q == (state_q == S_DONE));
    a_err_done: assert property (@(posedge clk) disable iff (!rst_n)
        err_q |-> done_q);

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller for the team's 8-bit universal shift register (one-hot controls: parallel load, shift left, shift right, rotate right, rotate left; serial input `si`). It accepts one command at a time through a valid/ready handshake and replays it as N consecutive one-hot strobe cycles. It also sources the serial-in bit for each step, then pulses `done`. It sits between the lab's control logic and the shift register, and is the only driver of the register's control inputs.

## Interface
- `CNT_W`, default 4: width of the step count; maximum steps per command is 2^CNT_W−1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  controller can accept a command; high iff state is IDLE.
- `cmd_op`  in  3  opcode:
  - 1 = load
  - 2 = shift left
  - 3 = shift right
  - 4 = rotate right
  - 5 = rotate left
  - 0, 6 and 7 are illegal.
- `cmd_cnt`  in  CNT_W  step count.
- `cmd_si`  in  8  serial-in pattern; step k uses bit k mod 8.
- `abort`  in  1  terminates a running command.
- `pl`, `sl`, `sr`, `rr`, `rl`  out  1 each  registered one-hot controls to the shift register.
- `si`  out  1  registered serial bit to the shift register.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle illegal-opcode pulse, coincident with `done`.

## Operation
- States:
  - IDLE: `cmd_ready` = 1.
  - RUN: strobes active.
  - DONE: one cycle, `done` = 1.
- IDLE → RUN: on `cmd_valid & cmd_ready` with a legal op and an effective count ≥ 1.
  - Latch op, `cmd_si`, and remaining count.
  - Load always has effective count 1; `cmd_cnt` is ignored for load.
- IDLE → DONE:
  - Legal shift/rotate op with `cmd_cnt` = 0: no strobes are issued.
  - Illegal op: `err` = 1 with `done`, and no strobes are issued.
- RUN:
  - Exactly one strobe (the one selected by op) is high on every RUN cycle.
  - The remaining count decrements each cycle; on the last step, next state is DONE.
- `si` behaviour:
  - During shift-left/right step k (k = 0..N−1), `si` = latched `cmd_si[k mod 8]`.
  - For load and rotates, `si` = 0.
- DONE → IDLE unconditionally.
- `abort`:
  - Sampled high in RUN: the next cycle has all strobes 0 and state DONE (`done` pulses, `err` = 0).
  - The step on which `abort` is sampled still executes.
  - Ignored in IDLE and DONE.
- `cmd_valid` while not ready: ignored, and the command is not latched. The requester holds it until accepted.
- Invariant: at most one of `pl`, `sl`, `sr`, `rr`, `rl` is high in any cycle. All five are 0 outside RUN.
- Counter width: CNT_W bits, no wrap. The count never decrements below 1 while in RUN.

## Timing
- Reset (`rst_n` low, any time, asynchronous):
  - State IDLE.
  - `pl`, `sl`, `sr`, `rr`, `rl`, `si`, `busy`, `done`, `err` all 0; `cmd_ready` = 1.
  - Internal latched op/count/pattern are cleared.
  - A reset during RUN drops strobes immediately, without waiting for a clock edge.
- Command accepted at edge T:
  - Strobes are high for cycles T+1 … T+N.
  - `done` is high in cycle T+N+1.
  - `cmd_ready` is high again from cycle T+N+2, so the earliest next accept is edge T+N+2.
- Load latency: `pl` in cycle T+1, `done` in cycle T+2.
- Zero-count or illegal op: `done` (plus `err` if illegal) in cycle T+1, `cmd_ready` in cycle T+2.
- `busy` = 1 exactly on the strobe cycles.
- All outputs except `cmd_ready` are registered. `cmd_ready` is decoded from the state register only and has no combinational path from inputs.

## Test plan
The bench pairs the block with the 8-bit universal shift register (power-up value 0xAA, parallel-load constant 0x99) and checks the register contents Q.

- Reset mid-RUN of a rotate-left command with count 5: strobes drop asynchronously; after release all outputs are 0, `cmd_ready` = 1, and Q stays at its value at the reset edge.
- Load (op 1, `cmd_cnt` = 9): `pl` high for exactly 1 cycle → Q = 0x99; `done` 1 cycle later; `err` = 0.
- After load, shift left (op 2, `cmd_cnt` = 3, `cmd_si` = 0x05):
  - `si` sequence is 1, 0, 1 over three `sl` cycles.
  - Q goes 0x33 → 0x66 → 0xCD.
  - `done` at T+4.
- Rotate right, count 8, starting from Q = 0xCD: eight `rr` cycles, Q returns to 0xCD; `busy` high 8 cycles; `cmd_valid` held high throughout is not accepted until `cmd_ready` returns at T+10.
- Rotate left with count 6, `abort` asserted on the 2nd strobe cycle, starting from Q = 0x99: exactly 2 `rl` strobes → Q = 0x66; `done` next cycle; `err` = 0.
- Op 7 with `cmd_cnt` = 4, then op 3 with `cmd_cnt` = 0:
  - Op 7: `done` and `err` together at T+1, no strobes, Q unchanged.
  - Op 3: `done` at T+1, `err` = 0, no strobes.
